// File: rtl/adc4xmit_pkg.sv
// Shared constants, mode codes and helpers for the ADC output emulator.
package adc4xmit_pkg;

  localparam int NCH    = 4;   // ADC channels
  localparam int NLANE  = 8;   // serial data lanes, two per channel
  localparam int SMP_W  = 12;  // sample width
  localparam int WORD_W = 6;   // lane word width (6:1 serializer)

  localparam logic [5:0]  FRAME_DEFAULT = 6'b111000;
  // Feedback taps for x^12+x^6+x^4+x+1 (bits 11, 5, 3, 0)
  localparam logic [11:0] LFSR_TAPS     = 12'h829;

  typedef enum logic [1:0] {
    MODE_FIFO  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  // One step of the Fibonacci LFSR; shifts toward the MSB.
  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    lfsr_next = {s[10:0], ^(s & LFSR_TAPS)};
  endfunction

  // Output word of the bit-offset shifter: low 6 bits of {prev,cur} >> off.
  function automatic logic [5:0] slip_word(input logic [5:0] p,
                                           input logic [5:0] w,
                                           input logic [2:0] off);
    logic [11:0] cat;
    cat = {p, w} >> off;
    slip_word = cat[5:0];
  endfunction

endpackage

// File: rtl/adc_smp_fifo.sv
// First-word-fall-through synchronous FIFO for user sample vectors.
module adc_smp_fifo
  import adc4xmit_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_r;
  logic [AW-1:0] rd_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_r];

  // Storage array write; contents need no reset since pointers define validity.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_r    <= '0;
      rd_r    <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) wr_r <= wr_r + AW'(1);
      if (do_pop_s)  rd_r <= rd_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc4xmit.sv
// ADC output emulator: selects a sample source, maps channels to lane words
// and applies a controllable bit offset ahead of an external 6:1 serializer.
module adc4xmit
  import adc4xmit_pkg::*;
#(
  parameter logic [5:0]  FRAME      = FRAME_DEFAULT,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [11:0] PRBS_SEED  = 12'hFFF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [1:0]  MODE,
  input  logic [11:0] CONST,
  input  logic [47:0] SDIN,
  input  logic        SVALID,
  output logic        SREADY,
  input  logic        SLIP,
  output logic [2:0]  OFFSET,
  output logic [47:0] DOUT,
  output logic [5:0]  FROUT,
  output logic [15:0] urun_cnt,
  input  logic        urun_reset
);

  logic [47:0] fifo_dout_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic        ready_en_r;

  logic [11:0] ramp_r;
  logic [11:0] lfsr_r;
  logic [47:0] held_r;
  logic [47:0] sel_s;
  logic        urun_s;
  logic [47:0] lane_s;
  logic [47:0] shf_s;
  logic [5:0]  fshf_s;
  logic [2:0]  off_nxt_s;

  logic [47:0] w_r;
  logic [47:0] p_r;
  logic [5:0]  fw_r;
  logic [5:0]  fp_r;
  logic [2:0]  off_r;
  logic [47:0] dout_r;
  logic [5:0]  frout_r;
  logic [15:0] urun_r;

  // SREADY stays low until the first clock after reset release.
  assign SREADY      = ready_en_r & ~fifo_full_s;
  assign fifo_push_s = SVALID & SREADY;

  adc_smp_fifo #(
    .W     (48),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (fifo_push_s),
    .din   (SDIN),
    .pop   (fifo_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Source select; user mode repeats the last popped vector on underrun.
  always_comb begin
    fifo_pop_s = 1'b0;
    urun_s     = 1'b0;
    sel_s      = held_r;
    case (MODE)
      MODE_FIFO: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          sel_s      = fifo_dout_s;
        end else begin
          urun_s = 1'b1;
          sel_s  = held_r;
        end
      end
      MODE_RAMP:  sel_s = {NCH{ramp_r}};
      MODE_CONST: sel_s = {NCH{CONST}};
      MODE_PRBS:  sel_s = {NCH{lfsr_r}};
      default:    sel_s = held_r;
    endcase
  end

  // Channel c feeds lane 2c with its upper half and lane 2c+1 with its lower half.
  always_comb begin
    lane_s = '0;
    for (int c = 0; c < NCH; c++) begin
      lane_s[12*c +: 6]     = sel_s[12*c+6 +: 6];
      lane_s[12*c+6 +: 6]   = sel_s[12*c +: 6];
    end
  end

  // Bit-offset shifter across previous and current word of every lane and frame.
  always_comb begin
    shf_s = '0;
    for (int i = 0; i < NLANE; i++) begin
      shf_s[6*i +: 6] = slip_word(p_r[6*i +: 6], w_r[6*i +: 6], off_r);
    end
    fshf_s = slip_word(fp_r, fw_r, off_r);
  end

  // Next bit offset, cycling 0..5 on each SLIP cycle.
  always_comb begin
    if (SLIP) begin
      off_nxt_s = (off_r == 3'd5) ? 3'd0 : off_r + 3'd1;
    end else begin
      off_nxt_s = off_r;
    end
  end

  // Free-running sources, held sample, FIFO ready enable and offset state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ramp_r     <= 12'h000;
      lfsr_r     <= PRBS_SEED;
      held_r     <= 48'h0;
      ready_en_r <= 1'b0;
      off_r      <= 3'd0;
    end else begin
      ramp_r     <= ramp_r + 12'd1;
      lfsr_r     <= lfsr_next(lfsr_r);
      held_r     <= fifo_pop_s ? fifo_dout_s : held_r;
      ready_en_r <= 1'b1;
      off_r      <= off_nxt_s;
    end
  end

  // Word pipeline: current/previous words feeding the registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      w_r     <= 48'h0;
      p_r     <= 48'h0;
      fw_r    <= 6'h00;
      fp_r    <= 6'h00;
      dout_r  <= 48'h0;
      frout_r <= 6'h00;
    end else begin
      w_r     <= lane_s;
      p_r     <= w_r;
      fw_r    <= FRAME;
      fp_r    <= fw_r;
      dout_r  <= shf_s;
      frout_r <= fshf_s;
    end
  end

  // Saturating underrun counter; the clear has priority over counting.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      urun_r <= 16'h0000;
    end else if (urun_reset) begin
      urun_r <= 16'h0000;
    end else if (urun_s && (urun_r != 16'hFFFF)) begin
      urun_r <= urun_r + 16'd1;
    end else begin
      urun_r <= urun_r;
    end
  end

  assign OFFSET   = off_r;
  assign DOUT     = dout_r;
  assign FROUT    = frout_r;
  assign urun_cnt = urun_r;

endmodule
